// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth digit consumer: decodes {single,double,neg} digits against a latched multiplicand
// and accumulates the signed 2*WIDTH product. Optional illegal-digit flag under BOOTH_DIGIT_CHECK_EN.
module booth_pp_accumulator #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic               digit_valid,
   output logic               digit_ready,
   input  logic               single,
   input  logic               double,
   input  logic               neg,
   output logic [2*WIDTH-1:0] product,
   output logic               product_valid,
   input  logic               product_ack,
   output logic               busy
`ifdef BOOTH_DIGIT_CHECK_EN
   ,
   output logic               digit_err
`endif
);

   localparam int NDIG  = WIDTH / 2;
   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(NDIG + 1);
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                   state_q, state_d;
   logic signed [WIDTH-1:0]  m_q, m_d;
   logic signed [PW-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic                     digit_accept;

   // Partial product at WIDTH+2 bits, sign-extended to PW and weighted by 4^idx.
   // A digit with both single and double set selects no magnitude and contributes 0.
   function automatic logic signed [PW-1:0] pp_term(
      input logic signed [WIDTH-1:0] m,
      input logic                    s,
      input logic                    d,
      input logic                    n,
      input logic [CNT_W-1:0]        idx
   );
      logic signed [WIDTH+1:0] mag;
      logic signed [WIDTH+1:0] pp;
      logic [PW-1:0]           ext;
      mag = '0;
      if (s && !d)
         mag = {{2{m[WIDTH-1]}}, m};
      else if (d && !s)
         mag = {m[WIDTH-1], m, 1'b0};
      pp  = n ? -mag : mag;
      ext = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp};
      return ext << {idx, 1'b0};
   endfunction

   assign digit_accept = digit_valid && (state_q == ACCUM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      m_d           = m_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      digit_ready   = 1'b0;
      product_valid = 1'b0;
      busy          = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = multiplicand;
               acc_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            digit_ready = 1'b1;
            busy        = 1'b1;
            if (digit_accept) begin
               acc_d = acc_q + pp_term(m_q, single, double, neg, cnt_q);
               cnt_d = cnt_q + 1'b1;
               if (single && double)
                  err_d = 1'b1;
               if (cnt_q == LAST_DIG)
                  state_d = DONE;
            end
         end
         DONE: begin
            product_valid = 1'b1;
            busy          = 1'b1;
            if (product_ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign product = acc_q;

`ifdef BOOTH_DIGIT_CHECK_EN
   assign digit_err = err_q;
`else
   // Error tracking is folded away when the check port is absent.
   logic unused_err;
   assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized + directed bench for booth_pp_accumulator (WIDTH=8) with an arithmetic reference model.
module tb_booth_pp_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  multiplicand;
   logic        digit_valid;
   logic        digit_ready;
   logic        single, double, neg;
   logic [15:0] product;
   logic        product_valid;
   logic        product_ack;
   logic        busy;
`ifdef BOOTH_DIGIT_CHECK_EN
   logic        digit_err;
`endif

   booth_pp_accumulator #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(multiplicand),
      .digit_valid(digit_valid), .digit_ready(digit_ready),
      .single(single), .double(double), .neg(neg),
      .product(product), .product_valid(product_valid),
      .product_ack(product_ack), .busy(busy)
`ifdef BOOTH_DIGIT_CHECK_EN
      , .digit_err(digit_err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int rise_cyc = 0;
   logic pv_prev = 1'b0;

   // Expected observable state, maintained by the stimulus process.
   int          exp_ready = 0, exp_valid = 0, exp_busy = 0;
   logic [15:0] exp_prod = '0;
   logic        exp_err = 1'b0;
   bit          chk_en = 1'b0;
   logic [2:0]  dq[4];          // {single, double, neg} per digit
   int          gap[4];
   logic [15:0] done_prod;
   bit          has_illegal;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (product_valid && !pv_prev) rise_cyc = cyc;
      pv_prev = product_valid;
      if (chk_en) begin
         check("digit_ready", digit_ready, exp_ready);
         check("product_valid", product_valid, exp_valid);
         check("busy", busy, exp_busy);
         if (exp_valid != 0) check("product", product, exp_prod);
`ifdef BOOTH_DIGIT_CHECK_EN
         check("digit_err", digit_err, exp_err);
`endif
      end
   end

   // Product = M * sum(d_i * 4^i), d_i in {0,+-1,+-2}; illegal digits count as 0.
   function automatic logic [15:0] model_prod(input logic signed [7:0] m);
      longint acc = 0;
      for (int i = 0; i < 4; i++) begin
         longint dv = 0;
         if (dq[i][2] && !dq[i][1]) dv = 1;
         else if (dq[i][1] && !dq[i][2]) dv = 2;
         if (dq[i][0]) dv = -dv;
         acc += longint'(m) * dv * (longint'(1) << (2 * i));
      end
      return acc[15:0];
   endfunction

   task automatic recode(input logic [7:0] x);
      logic [8:0] xe;
      xe = {x, 1'b0};
      for (int i = 0; i < 4; i++) begin
         int v;
         v = -2 * int'(xe[2*i+2]) + int'(xe[2*i+1]) + int'(xe[2*i]);
         if (v == 0) dq[i] = {2'b00, 1'($urandom % 2)};
         else dq[i] = {(v == 1 || v == -1), (v == 2 || v == -2), (v < 0)};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      exp_ready = 0; exp_valid = 0; exp_busy = 0;
   endtask

   task automatic run_product(input logic signed [7:0] m, input int ack_dly,
                              input bit start_in_done, input bit start_with_ack);
      multiplicand = m;
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
      multiplicand = 8'($urandom);
      exp_ready = 1; exp_busy = 1; exp_valid = 0; exp_err = 1'b0;
      has_illegal = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap[i]; g++) begin
            digit_valid = 1'b0;
            {single, double, neg} = 3'($urandom);
            tick();
         end
         digit_valid = 1'b1;
         {single, double, neg} = dq[i];
         tick();
         if (dq[i][2] && dq[i][1]) begin
            exp_err = 1'b1;
            has_illegal = 1'b1;
         end
      end
      digit_valid = 1'b0;
      exp_ready = 0; exp_valid = 1; exp_prod = model_prod(m);
      done_prod = product;
      for (int k = 0; k < ack_dly; k++) begin
         start = start_in_done ? 1'($urandom % 2) : 1'b0;
         tick();
      end
      start = start_with_ack;
      product_ack = 1'b1;
      tick();
      product_ack = 1'b0;
      start = 1'b0;
      set_idle();
   endtask

   initial begin
      int p;
      logic signed [7:0] rm, rx;
      rst_n = 1'b0; start = 0; multiplicand = 0; digit_valid = 0;
      single = 0; double = 0; neg = 0; product_ack = 0;
      tick(); tick();
      check("rst_product", product, 16'h0000);
      check("rst_valid", product_valid, 1'b0);
      check("rst_ready", digit_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      set_idle();
      chk_en = 1'b1;
      tick();

      // Model pins against hand-computed values.
      dq = '{3'b101, 3'b100, 3'b000, 3'b000};
      check("model_pin_5x3", model_prod(8'sd5), 16'h000F);
      dq = '{3'b000, 3'b000, 3'b000, 3'b011};
      check("model_pin_m128sq", model_prod(-8'sd128), 16'h4000);
      dq = '{3'b101, 3'b000, 3'b000, 3'b010};
      check("model_pin_127sq", model_prod(8'sd127), 16'h3F01);

      // 5 x 3, back-to-back digits.
      dq = '{3'b101, 3'b100, 3'b000, 3'b000};
      gap = '{0, 0, 0, 0};
      run_product(8'sd5, 1, 0, 0);
      check("d1_product", done_prod, 16'h000F);
      check("d1_latency", rise_cyc - start_cyc, 5);

      // -128 x -128.
      dq = '{3'b000, 3'b000, 3'b000, 3'b011};
      run_product(-8'sd128, 0, 0, 0);
      check("d2_product", done_prod, 16'h4000);

      // 127 x 127 with two idle cycles inside the digit stream.
      dq = '{3'b101, 3'b000, 3'b000, 3'b010};
      gap = '{0, 1, 1, 0};
      run_product(8'sd127, 0, 0, 0);
      check("d3_product", done_prod, 16'h3F01);
      check("d3_latency", rise_cyc - start_cyc, 7);

      // Long wait in DONE with start pulses, start coinciding with ack.
      recode(8'hF9);
      gap = '{0, 0, 0, 0};
      run_product(-8'sd3, 10, 1, 1);
      check("d4_product", done_prod, 16'd21);
      tick();
      recode(-8'sd50);
      run_product(8'sd100, 2, 0, 0);
      check("d4_second", done_prod, 16'hEC78);

      // Asynchronous reset after two digits.
      recode(8'h5A);
      multiplicand = 8'sd77; start = 1'b1; tick(); start = 1'b0;
      exp_ready = 1; exp_busy = 1; exp_err = 1'b0;
      for (int i = 0; i < 2; i++) begin
         digit_valid = 1'b1; {single, double, neg} = dq[i]; tick();
      end
      digit_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_product", product, 16'h0000);
      check("arst_valid", product_valid, 1'b0);
      check("arst_ready", digit_ready, 1'b0);
      check("arst_busy", busy, 1'b0);
      set_idle(); exp_err = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      rm = -8'sd77; rx = 8'sd93;
      recode(rx);
      run_product(rm, 0, 0, 0);
      p = int'(rm) * int'(rx);
      check("arst_after", done_prod, p[15:0]);

`ifdef BOOTH_DIGIT_CHECK_EN
      dq = '{3'b101, 3'b110, 3'b000, 3'b000};
      run_product(8'sd5, 1, 0, 0);
      check("err_product", done_prod, 16'hFFFB);
      check("err_flag_idle", digit_err, 1'b1);
      recode(8'd3);
      run_product(8'sd5, 0, 0, 0);
      check("err_cleared", digit_err, 1'b0);
`endif

      // Randomized products from Booth-recoded multipliers.
      for (int n = 0; n < 40; n++) begin
         rm = 8'($urandom);
         rx = 8'($urandom);
         recode(rx);
         if ($urandom % 8 == 0) dq[$urandom % 4] = {2'b11, 1'($urandom % 2)};
         for (int i = 0; i < 4; i++) gap[i] = $urandom % 3;
         run_product(rm, $urandom % 4, 1'($urandom % 2), 1'($urandom % 2));
         if (!has_illegal) begin
            p = int'(rm) * int'(rx);
            check("rand_exact", done_prod, p[15:0]);
         end
         if ($urandom % 2 == 0) tick();
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
